// File: rtl/bcd_convert_arbiter.sv
// Two-requester arbiter in front of a serial double-dabble binary-to-BCD converter.
// The priority pointer alternates on every accept; one conversion takes 8 shift cycles.
module bcd_convert_arbiter #(
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic        out_valid,
  output logic [11:0] out_bcd,
  output logic        out_id,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [7:0]   opnd_q;
  logic [3:0]   hund_q, tens_q, units_q;
  logic [2:0]   cnt_q;
  logic         id_q;
  logic         prio_q;
  logic [11:0]  result_q;

  logic         any_valid;
  logic         grant_id;
  logic         accept;
  logic [3:0]   hund_adj, tens_adj, units_adj;
  logic [19:0]  shifted;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d > 4'd4) ? d + 4'd3 : d;
  endfunction

  // Contention goes to the pointer; a lone requester wins regardless of it.
  assign any_valid  = req0_valid | req1_valid;
  assign grant_id   = (req0_valid & req1_valid) ? prio_q : req1_valid;
  assign accept     = (state_q == IDLE) & any_valid;
  assign req0_ready = accept & ~grant_id;
  assign req1_ready = accept &  grant_id;

  assign hund_adj  = add3(hund_q);
  assign tens_adj  = add3(tens_q);
  assign units_adj = add3(units_q);
  assign shifted   = {hund_adj, tens_adj, units_adj, opnd_q} << 1;

  always_comb begin
    // NOTE: next state defaults to the current one so every path assigns it and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)          state_d = SHIFT;
      SHIFT:   if (cnt_q == 3'd7)   state_d = DONE;
      DONE:    if (out_ready)       state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_q   <= '0;
      hund_q   <= '0;
      tens_q   <= '0;
      units_q  <= '0;
      cnt_q    <= '0;
      id_q     <= 1'b0;
      prio_q   <= PRIO_RESET;
      result_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            opnd_q  <= grant_id ? req1_data : req0_data;
            id_q    <= grant_id;
            prio_q  <= ~grant_id;
            hund_q  <= '0;
            tens_q  <= '0;
            units_q <= '0;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          hund_q  <= shifted[19:16];
          tens_q  <= shifted[15:12];
          units_q <= shifted[11:8];
          opnd_q  <= shifted[7:0];
          cnt_q   <= cnt_q + 3'd1;
          // The published result only changes on the final shift, so it survives the next accept.
          if (cnt_q == 3'd7) result_q <= shifted[19:8];
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_bcd   = result_q;
  assign out_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/bcd_convert_arbiter.md
BCD_CONVERT_ARBITER -- requirements
Module: bcd_convert_arbiter

Interface
REQ-001 Parameter: PRIO_RESET, default 0, index of the requester that holds priority after reset; the only legal values are 0 and 1.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req0_valid  input  1  requester 0 has an operand pending.
REQ-005 req0_data  input  8  requester 0 unsigned binary operand, 0..255.
REQ-006 req0_ready  output  1  requester 0 operand accepted this cycle when req0_valid is also high.
REQ-007 req1_valid  input  1  requester 1 has an operand pending.
REQ-008 req1_data  input  8  requester 1 unsigned binary operand, 0..255.
REQ-009 req1_ready  output  1  requester 1 operand accepted this cycle when req1_valid is also high.
REQ-010 out_valid  output  1  conversion result is available.
REQ-011 out_bcd  output  12  result: hundreds digit in [11:8], tens in [7:4], units in [3:0].
REQ-012 out_id  output  1  index of the requester that owns the result.
REQ-013 out_ready  input  1  consumer takes the result when out_valid is also high.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-016 In IDLE, reqN_ready SHALL be high only for the granted requester; both readies SHALL be low in SHIFT and DONE.
REQ-017 Grant: if exactly one valid is high, that requester is granted; if both are high, the requester named by the priority pointer is granted; if neither is high, there is no grant.
REQ-018 On an accept edge (IDLE, valid&ready), the block SHALL capture the operand and the id, clear the digit registers and the 3-bit count, and enter SHIFT.
REQ-019 On an accept edge, the priority pointer SHALL be set to the requester not granted.
REQ-020 Each SHIFT cycle SHALL first add 3 to every digit greater than 4, then shift {hundreds,tens,units,operand} left by one bit, with the operand MSB entering units bit 0.
REQ-021 Exactly 8 SHIFT cycles SHALL occur; the edge at count 7 SHALL enter DONE.
REQ-022 Latency: out_valid SHALL rise in the 9th cycle after the accept edge.
REQ-023 In DONE, out_valid SHALL be high, and out_bcd and out_id SHALL be held stable until the out_ready edge.
REQ-024 The out_ready edge SHALL move the FSM to IDLE; out_valid SHALL be low in IDLE and SHIFT.
REQ-025 out_bcd SHALL retain its last result outside DONE, and each digit SHALL never exceed 9.
REQ-026 The minimum accept-to-accept interval SHALL be 10 cycles when out_ready is held high.
REQ-027 Valid inputs SHALL be ignored in SHIFT and DONE.
REQ-028 A requester dropping valid before it is accepted SHALL lose nothing already accepted and SHALL not be granted.
REQ-029 out_ready while out_valid is low SHALL have no effect.

Reset
REQ-030 While rst_n is low, the block SHALL be in IDLE with out_valid=0, out_bcd=0x000, out_id=0, busy=0, count=0 and priority pointer=PRIO_RESET.
REQ-031 Assertion of rst_n in SHIFT or DONE SHALL abandon the conversion immediately, with no out_valid pulse afterwards.
REQ-032 Operation SHALL resume on the first rising edge after rst_n deasserts.

Verification
REQ-033 req0 255 alone, out_ready=1 -> out_bcd=0x255, out_id=0, out_valid high 9 cycles after accept for 1 cycle.
REQ-034 Sweep 0..255 from req1 -> out_bcd equals decimal digits each time (0->0x000, 99->0x099, 100->0x100).
REQ-035 PRIO_RESET=0, req0=200 and req1=37 both valid after reset -> 0x200/id0 first, then 0x037/id1; repeating both -> results alternate id0, id1.
REQ-036 out_ready low 5 cycles in DONE -> out_valid, out_bcd and out_id stable; both readies low; result taken on the first out_ready edge.
REQ-037 rst_n pulsed low during SHIFT cycle 4 of operand 128 -> outputs at reset values, no out_valid, next operand 7 -> 0x007.
